gb_cpu_interrupt_ctrl: RTL and testbench

Interrupt controller for the Game Boy CPU, the responder side of the scheduler's interrupt handshake. It holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME master enable, including the one-instruction EI delay. It raises `interrupt_queued` to the scheduler at instruction boundaries and serves the scheduler's `write_interrupt_vector` and `clear_interrupt_flag` control strobes during ISR dispatch. It also provides the HALT wake condition.

---
 rtl/gb_cpu_interrupt_ctrl.sv | 55 +++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl: IF/IE/IME interrupt controller serving scheduler dispatch strobes, bus reads/writes and HALT wake
module gb_cpu_interrupt_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_boundary,
  input  logic        enable_interrupts,
  input  logic        disable_interrupts,
  input  logic        write_interrupt_vector,
  input  logic        clear_interrupt_flag,
  input  logic [4:0]  irq_req,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_wren,
  output logic [7:0]  reg_rdata,
  output logic        interrupt_queued,
  output logic [7:0]  int_vector,
  output logic        ime,
  output logic        wake
);
  typedef enum logic [1:0] {OFF, PEND, ON} state_t;
  state_t state;
  logic [4:0] if_r, pending, if_base, if_clr;
  logic [7:0] ie_r;
  logic [2:0] disp_idx, win;
  logic disp_valid;
  assign pending = ie_r[4:0] & if_r;
  assign win = pending[0] ? 3'd0 : pending[1] ? 3'd1 : pending[2] ? 3'd2 : pending[3] ? 3'd3 : 3'd4;
  assign if_base = (reg_wren && reg_addr == 16'hFF0F) ? reg_wdata[4:0] : if_r;
  assign if_clr = (clear_interrupt_flag && disp_valid) ? if_base & ~(5'd1 << disp_idx) : if_base;
  assign reg_rdata = reg_addr == 16'hFF0F ? {3'b111, if_r} : reg_addr == 16'hFFFF ? ie_r : 8'h00;
  assign wake = |pending;
  assign ime = state == ON;
  assign interrupt_queued = ime && wake;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= OFF;
      if_r       <= 5'd0;
      ie_r       <= 8'd0;
      int_vector <= 8'd0;
      disp_valid <= 1'b0;
      disp_idx   <= 3'd0;
    end else begin
      if_r <= if_clr | irq_req;
      if (reg_wren && reg_addr == 16'hFFFF) ie_r <= reg_wdata;
      if (disable_interrupts || write_interrupt_vector) state <= OFF;
      else if (enable_interrupts && state == OFF) state <= PEND;
      else if (state == PEND && instr_boundary) state <= ON;
      if (write_interrupt_vector) begin
        disp_valid <= |pending;
        disp_idx   <= win;
        int_vector <= |pending ? {2'b01, win, 3'b000} : 8'h00;
      end else if (clear_interrupt_flag) disp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// tb_gb_cpu_interrupt_ctrl: directed stimulus with a cycle-tagged scoreboard checked by a negedge monitor
module tb_gb_cpu_interrupt_ctrl;
  logic clk = 0, reset = 0, bnd = 0, ei = 0, di = 0, wiv = 0, clr = 0, wren = 0;
  logic [4:0] irq = 0;
  logic [15:0] addr = 16'h0000;
  logic [7:0] wdata = 0, rdata, vec;
  logic iq, ime, wake;
  int cyc = 0, total = 0, bad = 0;
  typedef struct {int cyc; string name; int sel; logic [7:0] exp;} exp_t;
  exp_t q[$];
  gb_cpu_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .instr_boundary(bnd), .enable_interrupts(ei),
    .disable_interrupts(di), .write_interrupt_vector(wiv), .clear_interrupt_flag(clr),
    .irq_req(irq), .reg_addr(addr), .reg_wdata(wdata), .reg_wren(wren),
    .reg_rdata(rdata), .interrupt_queued(iq), .int_vector(vec), .ime(ime), .wake(wake)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] act(int sel);
    return sel == 0 ? rdata : sel == 1 ? {7'd0, iq} : sel == 2 ? vec : sel == 3 ? {7'd0, ime} : {7'd0, wake};
  endfunction
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        total++;
        if (q[i].cyc < cyc || act(q[i].sel) !== q[i].exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", q[i].name, cyc, act(q[i].sel), q[i].exp);
        end
        q.delete(i);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    {reset, bnd, ei, di, wiv, clr, wren} = '0;
    irq = 0;
  endtask
  task automatic chk(int off, string n, int sel, logic [7:0] e);
    q.push_back('{cyc + off, n, sel, e});
  endtask
  task automatic wr(logic [15:0] a, logic [7:0] d);
    addr = a;
    wdata = d;
    wren = 1;
  endtask
  initial begin
    step(); reset = 1;
    step(); reset = 1;
    step(); addr = 16'hFF0F;
    chk(0, "rst_if", 0, 8'hE0); chk(0, "rst_iq", 1, 0); chk(0, "rst_ime", 3, 0);
    chk(0, "rst_vec", 2, 0); chk(0, "rst_wake", 4, 0);
    step(); addr = 16'hFFFF; chk(0, "rst_ie", 0, 8'h00);
    step(); addr = 16'h1234; chk(0, "other_addr", 0, 8'h00);
    // EI delay
    step(); wr(16'hFFFF, 8'h04);
    step(); irq = 5'h04; chk(1, "ei_wake", 4, 1);
    step(); ei = 1; bnd = 1;
    for (int k = 0; k < 5; k++) chk(k, "ei_iq_low", 1, 0);
    step();
    step();
    step();
    step(); bnd = 1; chk(0, "ei_ime_low", 3, 0);
    chk(1, "ei_iq_high", 1, 1); chk(1, "ei_ime_high", 3, 1);
    // priority dispatch
    step(); wr(16'hFFFF, 8'h1F);
    step(); wr(16'hFF0F, 8'h1A);
    step(); addr = 16'hFF0F; wiv = 1; chk(0, "pri_iq", 1, 1); chk(0, "pri_if", 0, 8'hFA);
    chk(1, "pri_vec", 2, 8'h48); chk(1, "pri_ime", 3, 0); chk(1, "pri_iq_drop", 1, 0);
    step(); clr = 1; chk(1, "pri_clr", 0, 8'hF8);
    step();
    // cancelled dispatch
    step(); wr(16'hFF0F, 8'h01);
    step(); wr(16'hFFFF, 8'h01);
    step(); ei = 1; bnd = 1;
    step(); bnd = 1;
    step(); chk(0, "can_ime", 3, 1); chk(0, "can_iq", 1, 1); wr(16'hFFFF, 8'h00);
    step(); wiv = 1; chk(0, "can_iq_off", 1, 0);
    step(); clr = 1; addr = 16'hFF0F; chk(0, "can_vec", 2, 8'h00); chk(0, "can_ime_off", 3, 0);
    chk(1, "can_if_kept", 0, 8'hE1);
    step();
    // clear/request collision on Timer
    step(); wr(16'hFFFF, 8'h04);
    step(); wr(16'hFF0F, 8'h04);
    step(); addr = 16'hFF0F; wiv = 1; chk(1, "col_vec", 2, 8'h50);
    step(); clr = 1; irq = 5'h04; chk(1, "col_if", 0, 8'hE4);
    step();
    // EI+DI same cycle, then HALT wake without IME
    step(); ei = 1; di = 1; chk(1, "eidi_ime", 3, 0); chk(2, "eidi_ime2", 3, 0);
    step(); bnd = 1;
    step(); wr(16'hFFFF, 8'h10);
    step(); irq = 5'h10; chk(0, "wake_low", 4, 0); chk(1, "wake_high", 4, 1); chk(1, "wake_iq", 1, 0);
    step(); addr = 16'hFFFF; chk(0, "ie_rb", 0, 8'h10);
    // reset mid-dispatch
    step(); wr(16'hFFFF, 8'h01);
    step(); irq = 5'h01;
    step(); wiv = 1; addr = 16'hFF0F; chk(1, "md_vec", 2, 8'h40);
    step(); reset = 1; clr = 1;
    step(); chk(0, "md_if", 0, 8'hE0); chk(0, "md_vec0", 2, 0); chk(0, "md_ime", 3, 0); chk(0, "md_iq", 1, 0);
    step(); addr = 16'hFFFF; chk(0, "md_ie", 0, 8'h00);
    step();
    step();
    if (q.size() != 0) begin
      bad += q.size();
      total += q.size();
      $display("FAIL leftover got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
